// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// Used by serial_subtractor (optional ovf output enabled by SERIAL_SUB_OVF_EN).
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH + 1);

  // Counter width for an arbitrary operand width (WIDTH is a module parameter).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = A - B - bin, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
//
// Handshake: start is sampled only while busy==0 (IDLE or DONE state); an
// accepted start captures A/B/bin, busy is high for exactly WIDTH cycles, then
// done pulses for one cycle with diff/bout (and ovf) valid and held until the
// next operation's done.
import serial_sub_pkg::*;

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       state_dbg
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr, b_sr;
  logic             br;
  logic [WIDTH-2:0] diff_sr;
  logic [WIDTH-1:0] diff_sr_next;
  logic [CW-1:0]    cnt;

  logic load, step, last;
  logic fs_d, fs_bout;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb;
`endif

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // The newest bit lands in the MSB; the oldest falls off the LSB end, so the
  // stored part only needs WIDTH-1 bits.
  assign diff_sr_next = {fs_d, diff_sr};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == CNT_LAST) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      br      <= 1'b0;
      diff_sr <= '0;
      cnt     <= '0;
      diff    <= '0;
      bout    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else if (load) begin
      a_sr  <= A;
      b_sr  <= B;
      br    <= bin;
      cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb <= A[WIDTH-1];
      b_msb <= B[WIDTH-1];
`endif
    end else if (step) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      br      <= fs_bout;
      diff_sr <= diff_sr_next[WIDTH-1:1];
      cnt     <= cnt + CW'(1);
      if (last) begin
        diff <= diff_sr_next;
        bout <= fs_bout;
`ifdef SERIAL_SUB_OVF_EN
        ovf  <= (a_msb != b_msb) && (fs_d != a_msb);
`endif
      end
    end
  end

  assign busy      = (state == SHIFT);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule
